// File: rtl/count_monitor.sv
// ============================================================================
//  Module   : count_monitor
//  Purpose  : Checks that a free-running counter advances by exactly +1 per clock
//             and reports wraps and sequence errors.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module count_monitor #(
   parameter int W      = 4,
   parameter int LOCK_N = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [W-1:0]     cnt_in,
   input  logic             cnt_rstn,
   input  logic             clr,
   output logic             locked,
   output logic             wrap_p,
   output logic             err_p,
   output logic             err_flag,
   output logic [CNT_W-1:0] wrap_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [W-1:0]     last_bad
);

   localparam int                 GOOD_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
   localparam logic [GOOD_W-1:0] C_LOCK = GOOD_W'(LOCK_N);

   typedef enum logic [0:0] {
      S_SYNC   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       prev_q, prev_d;
   logic [GOOD_W-1:0]  good_q, good_d;
   logic               locked_q, locked_d;
   logic               wrap_p_q, wrap_p_d;
   logic               err_p_q, err_p_d;
   logic               err_flag_q, err_flag_d;
   logic [CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [W-1:0]       last_bad_q, last_bad_d;

   logic [W-1:0]       w_exp;
   logic [GOOD_W-1:0]  w_good_inc;
   logic [CNT_W-1:0]   w_wrap_base;
   logic [CNT_W-1:0]   w_err_base;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      w_exp       = prev_q + 1'b1;
      w_good_inc  = good_q + 1'b1;
      // clr zeroes the tallies first so a same-edge event lands on top of zero
      w_wrap_base = clr ? '0 : wrap_cnt_q;
      w_err_base  = clr ? '0 : err_cnt_q;

      state_d    = state_q;
      prev_d     = cnt_in;
      good_d     = good_q;
      locked_d   = locked_q;
      wrap_p_d   = 1'b0;
      err_p_d    = 1'b0;
      err_flag_d = clr ? 1'b0 : err_flag_q;
      wrap_cnt_d = w_wrap_base;
      err_cnt_d  = w_err_base;
      last_bad_d = last_bad_q;

      if (!cnt_rstn) begin
         state_d  = S_SYNC;
         good_d   = '0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            S_SYNC: begin
               if (cnt_in == w_exp) begin
                  if (w_good_inc >= C_LOCK) begin
                     state_d  = S_LOCKED;
                     locked_d = 1'b1;
                     good_d   = '0;
                  end else begin
                     good_d = w_good_inc;
                  end
               end else begin
                  good_d = '0;
               end
            end
            S_LOCKED: begin
               if (cnt_in == w_exp) begin
                  if (&prev_q) begin
                     wrap_p_d   = 1'b1;
                     wrap_cnt_d = sat_inc(w_wrap_base);
                  end
               end else begin
                  err_p_d    = 1'b1;
                  err_flag_d = 1'b1;
                  err_cnt_d  = sat_inc(w_err_base);
                  last_bad_d = cnt_in;
                  state_d    = S_SYNC;
                  good_d     = '0;
                  locked_d   = 1'b0;
               end
            end
            default: begin
               state_d  = S_SYNC;
               good_d   = '0;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_SYNC;
         prev_q     <= '0;
         good_q     <= '0;
         locked_q   <= 1'b0;
         wrap_p_q   <= 1'b0;
         err_p_q    <= 1'b0;
         err_flag_q <= 1'b0;
         wrap_cnt_q <= '0;
         err_cnt_q  <= '0;
         last_bad_q <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         good_q     <= good_d;
         locked_q   <= locked_d;
         wrap_p_q   <= wrap_p_d;
         err_p_q    <= err_p_d;
         err_flag_q <= err_flag_d;
         wrap_cnt_q <= wrap_cnt_d;
         err_cnt_q  <= err_cnt_d;
         last_bad_q <= last_bad_d;
      end
   end

   assign locked   = locked_q;
   assign wrap_p   = wrap_p_q;
   assign err_p    = err_p_q;
   assign err_flag = err_flag_q;
   assign wrap_cnt = wrap_cnt_q;
   assign err_cnt  = err_cnt_q;
   assign last_bad = last_bad_q;

endmodule

`default_nettype wire
